// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: receive FSM states, default frame size and
// opcode encodings used by the memory/command logic.
package spi_pkg;

  localparam int FRAME_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    OVR   = 2'd3
  } state_e;

  // Opcode field occupies the top two bits of a frame; decoded downstream.
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_rx.sv
// SPI slave receive path: samples MOSI on posedge while SS_n is low, assembles
// an MSB-first frame, pulses rx_valid on completion and frame_err on misframing.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter  int FRAME_W = FRAME_W_DEFAULT,
  localparam int CNT_W   = $clog2(FRAME_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // The oldest bit is never needed before the word completes, so only
  // FRAME_W-1 bits are stored; the final bit comes straight from MOSI.
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [FRAME_W-1:0] word;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;

  assign word = {shift_q, MOSI};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (!SS_n) shift_d = word[FRAME_W-2:0];
    case (state_q)
      IDLE: begin
        if (!SS_n) begin
          state_d = SHIFT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (SS_n) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q == CNT_W'(FRAME_W - 1)) begin
          rx_data_d  = word;
          rx_valid_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (SS_n) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = OVR;
        end
      end
      OVR: begin
        if (SS_n) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: master drives on negedge, outputs are
// sampled 1 time unit after each posedge.
module tb_spi_slave_rx;
  localparam int FW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          SS_n = 1'b1;
  logic          MOSI = 1'b0;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;

  spi_slave_rx #(.FRAME_W(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nv, ne, pv, pe, edge_i;
  logic [FW-1:0] vdata;
  logic busy_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    nv = 0; ne = 0; pv = 0; pe = 0; edge_i = 0; vdata = '0;
  endtask

  task automatic step(input logic ss, input logic b);
    @(negedge clk);
    SS_n = ss;
    MOSI = b;
    @(posedge clk);
    #1;
    edge_i++;
    if (rx_valid === 1'b1) begin nv++; pv = edge_i; vdata = rx_data; end
    if (frame_err === 1'b1) begin ne++; pe = edge_i; end
    chk("pulse_exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
  endtask

  // nlow edges with SS_n low (bits beyond FW are 1s), then one deselect edge.
  task automatic frame(input logic [FW-1:0] d, input int nlow);
    clr_stats();
    for (int i = 0; i < nlow; i++) step(1'b0, (i < FW) ? d[FW-1-i] : 1'b1);
    busy_low = busy;
    step(1'b1, 1'b0);
  endtask

  initial begin
    logic [FW-1:0] d;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal frame 10'h2C3
    frame(10'h2C3, 10);
    chk("nom_nvalid", 32'(nv), 32'd1);
    chk("nom_valid_edge", 32'(pv), 32'd10);
    chk("nom_vdata", 32'(vdata), 32'h2C3);
    chk("nom_nerr", 32'(ne), 32'd0);
    chk("nom_busy_low", {31'b0, busy_low}, 32'd1);
    chk("nom_busy_after", {31'b0, busy}, 32'd0);
    chk("nom_rx_data_held", 32'(rx_data), 32'h2C3);

    // Reset mid-frame after 4 bits of 10'h2A5
    clr_stats();
    d = 10'h2A5;
    for (int i = 0; i < 4; i++) step(1'b0, d[FW-1-i]);
    chk("mid_busy_before_rst", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rx_data", 32'(rx_data), 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_valid", {31'b0, rx_valid}, 32'd0);
    chk("mid_rst_err", {31'b0, frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    SS_n = 1'b1;
    clr_stats();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rel_no_valid", 32'(nv), 32'd0);
    chk("rel_no_err", 32'(ne), 32'd0);
    frame(10'h2A5, 10);
    chk("post_rst_nvalid", 32'(nv), 32'd1);
    chk("post_rst_vdata", 32'(vdata), 32'h2A5);
    chk("post_rst_nerr", 32'(ne), 32'd0);

    // Short frame: 6 bits then deselect
    frame(10'h155, 6);
    chk("short_nerr", 32'(ne), 32'd1);
    chk("short_err_edge", 32'(pe), 32'd7);
    chk("short_nvalid", 32'(nv), 32'd0);
    chk("short_rx_data_kept", 32'(rx_data), 32'h2A5);
    chk("short_busy_after", {31'b0, busy}, 32'd0);
    step(1'b1, 1'b0);
    chk("short_err_one_cycle", {31'b0, frame_err}, 32'd0);

    // Long frame: 13 edges low
    frame(10'h1E7, 13);
    chk("long_nvalid", 32'(nv), 32'd1);
    chk("long_valid_edge", 32'(pv), 32'd10);
    chk("long_nerr", 32'(ne), 32'd1);
    chk("long_err_edge", 32'(pe), 32'd11);
    chk("long_rx_data", 32'(rx_data), 32'h1E7);
    chk("long_busy_low", {31'b0, busy_low}, 32'd1);
    chk("long_busy_after", {31'b0, busy}, 32'd0);

    // Back-to-back, one deselect edge between
    frame(10'h3FF, 10);
    chk("b2b_a_nvalid", 32'(nv), 32'd1);
    chk("b2b_a_vdata", 32'(vdata), 32'h3FF);
    chk("b2b_a_nerr", 32'(ne), 32'd0);
    frame(10'h000, 10);
    chk("b2b_b_nvalid", 32'(nv), 32'd1);
    chk("b2b_b_valid_edge", 32'(pv), 32'd10);
    chk("b2b_b_vdata", 32'(vdata), 32'h000);
    chk("b2b_b_nerr", 32'(ne), 32'd0);

    // Glitch: single low edge
    frame(10'h200, 1);
    chk("glitch_busy_low", {31'b0, busy_low}, 32'd1);
    chk("glitch_nerr", 32'(ne), 32'd1);
    chk("glitch_err_edge", 32'(pe), 32'd2);
    chk("glitch_nvalid", 32'(nv), 32'd0);
    chk("glitch_busy_after", {31'b0, busy}, 32'd0);
    chk("glitch_rx_data_kept", 32'(rx_data), 32'h000);

    // Recovery frame after glitch
    frame(10'h0C6, 10);
    chk("recov_nvalid", 32'(nv), 32'd1);
    chk("recov_vdata", 32'(vdata), 32'h0C6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
